// File: rtl/vram_scanout_if.sv
// Frame-buffer read port plus the pixel stream towards the ILI9341 driver.
// Pixels are RGB565 (the ILI9341 colour format) unless COLOR_W is overridden.
interface vram_scanout_if #(
    parameter int L       = 32,
    parameter int COLOR_W = 16
);
    localparam int AW = $clog2(L);

    logic               rd_ena;
    logic [AW-1:0]      rd_addr;
    logic [COLOR_W-1:0] rd_data;
    logic [COLOR_W-1:0] pixel_data;
    logic               pixel_valid;
    logic               pixel_ready;
    logic               pixel_sof;
    logic               pixel_eol;

    modport master (
        output rd_ena, rd_addr, pixel_data, pixel_valid, pixel_sof, pixel_eol,
        input  rd_data, pixel_ready
    );

    modport slave (
        input  rd_ena, rd_addr, pixel_data, pixel_valid, pixel_sof, pixel_eol,
        output rd_data, pixel_ready
    );
endinterface

// File: rtl/vram_scanout.sv
// Streams one frame (L pixels, row-major) out of VRAM into a valid/ready pixel
// stream, absorbing backpressure with a 2-entry skid FIFO and read credits.
module vram_scanout #(
    parameter int L             = 32,
    parameter int DISPLAY_WIDTH = 240,
    parameter int COLOR_W       = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start_i,
    output logic           busy_o,
    output logic           frame_done_o,
    vram_scanout_if.master bus
);
    localparam int AW = $clog2(L);
    localparam int CW = $clog2(L + 1);
    localparam int RW = $clog2(DISPLAY_WIDTH);
    localparam logic [CW-1:0] READS_ALL = CW'(L);
    localparam logic [AW-1:0] BEAT_LAST = AW'(L - 1);
    localparam logic [RW-1:0] ROW_LAST  = RW'(DISPLAY_WIDTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DONE} state_t;

    state_t             state_q;
    logic [CW-1:0]      reads_q;
    logic [AW-1:0]      beat_q;
    logic [RW-1:0]      row_q;
    logic               inflight_q;
    logic               busy_q;
    logic               done_q;
    logic [1:0]         count_q, count_d;
    logic [COLOR_W-1:0] head_q, head_d;
    logic [COLOR_W-1:0] tail_q, tail_d;
    logic               pop;
    logic               push;
    logic               rd_ena;
    logic [2:0]         credit;

    // A read may only issue if its pixel is guaranteed a FIFO slot on arrival.
    always_comb begin
        pop    = (count_q != 2'd0) && bus.pixel_ready;
        push   = inflight_q;
        credit = 3'(count_q) + 3'(inflight_q) - 3'(pop);
        rd_ena = (state_q == S_STREAM) && (reads_q < READS_ALL) && (credit < 3'd2);
    end

    always_comb begin
        count_d = count_q;
        head_d  = head_q;
        tail_d  = tail_q;
        case ({push, pop})
            2'b10: begin
                if (count_q == 2'd0) begin
                    head_d = bus.rd_data;
                end else begin
                    tail_d = bus.rd_data;
                end
                count_d = count_q + 2'd1;
            end
            2'b01: begin
                head_d  = tail_q;
                count_d = count_q - 2'd1;
            end
            2'b11: begin
                if (count_q == 2'd1) begin
                    head_d = bus.rd_data;
                end else begin
                    head_d = tail_q;
                    tail_d = bus.rd_data;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        head_q <= head_d;
        tail_q <= tail_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            reads_q    <= '0;
            beat_q     <= '0;
            row_q      <= '0;
            count_q    <= 2'd0;
            inflight_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    reads_q    <= '0;
                    beat_q     <= '0;
                    row_q      <= '0;
                    count_q    <= 2'd0;
                    inflight_q <= 1'b0;
                    if (start_i) begin
                        state_q <= S_STREAM;
                        busy_q  <= 1'b1;
                    end
                end
                S_STREAM: begin
                    count_q    <= count_d;
                    inflight_q <= rd_ena;
                    if (rd_ena) begin
                        reads_q <= reads_q + CW'(1);
                    end
                    if (pop) begin
                        row_q <= (row_q == ROW_LAST) ? '0 : row_q + RW'(1);
                        if (beat_q == BEAT_LAST) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            beat_q <= beat_q + AW'(1);
                        end
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Head qualifiers come from beat/row counters that only move on beats,
    // so they stay stable across stalls.
    assign bus.rd_ena      = rd_ena;
    assign bus.rd_addr     = reads_q[AW-1:0];
    assign bus.pixel_valid = (count_q != 2'd0);
    assign bus.pixel_data  = head_q;
    assign bus.pixel_sof   = (count_q != 2'd0) && (beat_q == '0);
    assign bus.pixel_eol   = (count_q != 2'd0) && ((row_q == ROW_LAST) || (beat_q == BEAT_LAST));
    assign busy_o          = busy_q;
    assign frame_done_o    = done_q;
endmodule
